// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory freeze with timeout.
// Optional stall-cycle performance counter enabled by macro HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int REGINDEX    = 5,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REGINDEX-1:0] id_rs1,
   input  logic [REGINDEX-1:0] id_rs2,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [REGINDEX-1:0] ex_rd,
   input  logic                ex_is_load,
   input  logic                ex_regwrite,
   input  logic                ex_branch_taken,
   input  logic                mem_req,
   input  logic                mem_ready,
   output logic                pc_en,
   output logic                ifid_en,
   output logic                idex_en,
   output logic                exmem_en,
   output logic                ifid_flush,
   output logic                idex_flush,
   output logic                mem_err,
   output logic [15:0]         stall_cnt
);

   typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

   state_t     state, state_nxt;
   logic [7:0] tmo_cnt, tmo_cnt_nxt;
   logic       hazard_ld;
   logic       freeze;

   assign hazard_ld = ex_is_load && ex_regwrite && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));
   assign freeze    = (state != ERR) && mem_req && !mem_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= tmo_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tmo_cnt_nxt = tmo_cnt;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      mem_err     = 1'b0;

      case (state)
         RUN: begin
            if (freeze) begin
               state_nxt   = MEMWAIT;
               tmo_cnt_nxt = 8'd1;
            end
         end
         MEMWAIT: begin
            if (!freeze) begin
               state_nxt   = RUN;
               tmo_cnt_nxt = '0;
            end else if (tmo_cnt == 8'(MEM_TIMEOUT - 1)) begin
               state_nxt = ERR;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 8'd1;
            end
         end
         default: state_nxt = ERR;
      endcase

      // Response priority: reset/ERR > freeze > branch > load-use > normal.
      if (rst || state == ERR) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         mem_err  = !rst;
      end else if (freeze) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (hazard_ld) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [15:0] perf_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cnt <= '0;
      end else if (!pc_en && perf_cnt != 16'hFFFF) begin
         perf_cnt <= perf_cnt + 16'd1;
      end
   end

   assign stall_cnt = perf_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with a cycle-level reference model.
module tb_pipe_hazard_ctrl;
   localparam int RI  = 5;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [RI-1:0] id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_is_load, ex_regwrite;
   logic          ex_branch_taken, mem_req, mem_ready;
   logic          pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, mem_err;
   logic [15:0]   stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_hazard_ctrl #(.REGINDEX(RI), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite),
      .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sticky error flag, run length of consecutive frozen cycles, stall total.
   bit m_err;
   int m_run;
   int m_perf;
   logic [6:0] e_vec;   // {pc, ifid, idex, exmem, ifid_flush, idex_flush, mem_err}
   logic m_hz, m_frz;

   always_comb begin
      m_hz  = ex_is_load && ex_regwrite && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      m_frz = !m_err && mem_req && !mem_ready;
      if (rst)                  e_vec = 7'b0000000;
      else if (m_err)           e_vec = 7'b0000001;
      else if (m_frz)           e_vec = 7'b0000000;
      else if (ex_branch_taken) e_vec = 7'b1111110;
      else if (m_hz)            e_vec = 7'b0011010;
      else                      e_vec = 7'b1111000;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_err  <= 1'b0;
         m_run  <= 0;
         m_perf <= 0;
      end else begin
         if (m_frz) begin
            m_run <= m_run + 1;
            if (m_run + 1 >= TMO) m_err <= 1'b1;
         end else begin
            m_run <= 0;
         end
         if (!e_vec[6] && m_perf < 65535) m_perf <= m_perf + 1;
      end
   end

   always @(negedge clk) begin
      chk("outputs_vs_model",
          {25'd0, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, mem_err},
          {25'd0, e_vec});
`ifdef HAZ_PERF_CNT_EN
      chk("stall_cnt_vs_model", {16'd0, stall_cnt}, m_perf);
`else
      chk("stall_cnt_vs_model", {16'd0, stall_cnt}, 32'd0);
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_regwrite = 0;
      ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      idle();
      tick();
      @(negedge clk);
      chk("reset_pc_en", pc_en, 0);
      chk("reset_mem_err", mem_err, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_normal", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
      tick();

      // Load-use on rs2
      ex_is_load = 1; ex_regwrite = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
      @(negedge clk);
      chk("ldu_stall", {pc_en, ifid_en, idex_flush}, 3'b001);
      tick();
      idle();
      @(negedge clk);
      chk("ldu_next_normal", pc_en, 1);
      tick();

      // Load to x0 never stalls
      ex_is_load = 1; ex_regwrite = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
      @(negedge clk);
      chk("x0_no_stall", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
      tick();

      // Matching index but the ID instruction does not read it
      ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 0;
      @(negedge clk);
      chk("unused_src_no_stall", pc_en, 1);
      tick();

      // Branch wins over load-use
      ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1; ex_branch_taken = 1;
      @(negedge clk);
      chk("branch_over_ldu", {ifid_flush, idex_flush, pc_en}, 3'b111);
      tick();
      idle();

      // Clean counter before the freeze scenario
      rst = 1; tick(); rst = 0; tick();

      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("freeze_pc_en", pc_en, 0);
         tick();
      end
      mem_ready = 1;
      @(negedge clk);
      chk("freeze_release", {pc_en, exmem_en}, 2'b11);
`ifdef HAZ_PERF_CNT_EN
      chk("freeze_stall_cnt", stall_cnt, 16'd3);
`endif
      tick();
      idle();

      // Branch held through a freeze is applied on the release cycle
      mem_req = 1; ex_branch_taken = 1;
      tick(); tick();
      mem_ready = 1;
      @(negedge clk);
      chk("branch_after_freeze", {pc_en, ifid_flush, idex_flush}, 3'b111);
      tick();
      idle();
      tick();

      // Timeout into ERR
      mem_req = 1; mem_ready = 0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mem_err) break;
         if (!pc_en) n++;
         tick();
      end
      chk("tmo_err_set", mem_err, 1);
      chk("tmo_frozen_cycles", n, TMO);
      tick();
      idle();
      mem_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("err_sticky", {mem_err, pc_en, ifid_flush}, 3'b100);
         tick();
      end
      rst = 1;
      @(negedge clk);
      chk("rst_clears_err", mem_err, 0);
      tick();
      rst = 0; idle();
      @(negedge clk);
      chk("after_err_normal", {pc_en, ifid_en, idex_en, exmem_en, mem_err}, 5'b11110);
      tick();

      // Reset in MEMWAIT
      mem_req = 1;
      tick(); tick();
      rst = 1;
      @(negedge clk);
      chk("rst_in_memwait", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
      tick();
      rst = 0; idle();
      @(negedge clk);
      chk("after_memwait_rst", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REGINDEX, default 5: register-index width.
REQ-002 Parameter MEM_TIMEOUT, default 16: maximum MEMWAIT cycles before fatal error; legal range 2..255.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset; synchronous and active-high.
REQ-005 Ports id_rs1 and id_rs2, input, REGINDEX each: source register indices of the instruction in ID.
REQ-006 Ports id_use_rs1 and id_use_rs2, input, 1 each: the ID instruction reads rs1 / rs2.
REQ-007 Port ex_rd, input, REGINDEX: destination index held in ID/EX.
REQ-008 Port ex_is_load, input, 1: the ID/EX instruction writes back from data memory.
REQ-009 Port ex_regwrite, input, 1: the ID/EX instruction writes the register file.
REQ-010 Port ex_branch_taken, input, 1: the EX stage resolved a taken branch or jump.
REQ-011 Port mem_req, input, 1: the MEM stage is issuing a data-memory access.
REQ-012 Port mem_ready, input, 1: data memory completes the access this cycle.
REQ-013 Ports pc_en, ifid_en, idex_en, exmem_en, output, 1 each: stage-register enables.
REQ-014 Ports ifid_flush and idex_flush, output, 1 each: load a bubble (NOP, regwrite=0, MemRw=0) into that stage register.
REQ-015 Port mem_err, output, 1: fatal memory timeout; sticky.
REQ-016 Port stall_cnt, output, 16: stall-cycle counter (see Configuration).

Function
REQ-017 The FSM SHALL have three states: RUN, MEMWAIT and ERR.
REQ-018 hazard_ld SHALL be true when ex_is_load & ex_regwrite & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-019 freeze SHALL be true when the state is RUN or MEMWAIT and mem_req=1 and mem_ready=0.
REQ-020 Outputs SHALL be combinational from state and inputs; there is zero-cycle latency from a hazard to its enable/flush response.
REQ-021 Priority SHALL be ERR > freeze > ex_branch_taken > hazard_ld > normal.
REQ-022 Normal response: all enables 1 and both flushes 0.
REQ-023 Freeze response: pc_en, ifid_en, idex_en and exmem_en all 0; flushes 0.
REQ-024 Branch response: all enables 1, ifid_flush=1 and idex_flush=1; a coincident hazard_ld is ignored.
REQ-025 Load-use response: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1; this inserts exactly one bubble per hazard.
REQ-026 Transition RUN->MEMWAIT SHALL occur on freeze; the timeout counter loads 1.
REQ-027 In MEMWAIT, mem_ready=1 (or mem_req=0) SHALL release the freeze in the same cycle and transition to RUN; otherwise the counter increments.
REQ-028 In MEMWAIT, when the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state SHALL be ERR.
REQ-029 In ERR, all enables and flushes SHALL be 0 and mem_err=1 until rst.
REQ-030 A branch taken during freeze SHALL NOT be lost: EX is held, so the branch response is applied on the release cycle.

Reset
REQ-031 While rst=1 the block SHALL hold state RUN, counter 0, mem_err=0 and stall_cnt=0, with all enables 0 and flushes 0.
REQ-032 rst SHALL override every state, including ERR and mid-MEMWAIT; normal response resumes in the first cycle after rst falls.

Configuration
REQ-033 Macro HAZ_PERF_CNT_EN, when defined, SHALL make stall_cnt increment on every non-reset cycle with pc_en=0 (freeze, load-use or ERR), saturating at 0xFFFF.
REQ-034 Without HAZ_PERF_CNT_EN, stall_cnt SHALL be tied to 0, the counter logic SHALL be absent, and the port list SHALL be unchanged.

Verification
REQ-035 Load-use: ex_is_load=1, ex_regwrite=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1; the next cycle is normal.
REQ-036 Load to x0: ex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall; all enables 1.
REQ-037 Branch plus load-use together -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-038 mem_req=1 with mem_ready rising after 3 cycles -> 3 frozen cycles, release on the 4th cycle; stall_cnt=3 with HAZ_PERF_CNT_EN defined.
REQ-039 mem_req=1, mem_ready=0 held with MEM_TIMEOUT=16 -> ERR entered after 16 frozen cycles; mem_err=1 stays set until rst; rst then clears it.
REQ-040 rst asserted in MEMWAIT -> the next cycle shows RUN, and after rst falls, with no active requests, all enables are 1.
